// File: rtl/opn_local_ni.sv
// ---------------------------------------------------------------------------
// opn_local_ni -- tile-side network interface on a router LOCAL port.
//
// Purpose
//   Far end of the router's req/ack link.
//   TX: queues flits from the execution tile and injects them as one-cycle
//       req pulses, resending the head flit until the router acks it.
//   RX: accepts every flit the router ejects, acks it one cycle later and
//       buffers it for the tile. A flit that arrives while the RX FIFO is
//       full is dropped (no ack) and rx_overflow latches.
//
// Optional feature
//   NI_ACK_TIMEOUT_EN : when defined, a retry counter raises the sticky
//                       timeout_err after TIMEOUT_CYC consecutive rejected
//                       attempts. When undefined, timeout_err is tied to 0.
//
// Parameters
//   TX_DEPTH    TX FIFO entries (power of 2, >= 2)
//   RX_DEPTH    RX FIFO entries (power of 2, >= 2)
//   TIMEOUT_CYC retries before timeout_err (NI_ACK_TIMEOUT_EN only)
//
// Ports
//   clk, rst      clock (posedge) and synchronous active-high reset
//   tx_valid/tx_flit/tx_ready   tile -> NI injection handshake
//   rx_valid/rx_flit/rx_ready   NI -> tile ejection handshake
//   net_req_out/net_flit_out    injection pulse + flit to router
//   net_ack_in                  router ack for the last injection
//   net_req_in/net_flit_in      ejection from router
//   net_ack_out                 registered ack for the last ejection
//   tx_idle      TX FIFO empty and TX FSM idle
//   rx_overflow  sticky: an ejected flit was dropped
//   timeout_err  sticky: ack never arrived within TIMEOUT_CYC retries
// ---------------------------------------------------------------------------

package opn_local_ni_pkg;
  typedef struct packed {
    logic [1:0]  ipriority;
    logic [3:0]  dst_x;
    logic [3:0]  dst_y;
    logic [31:0] payload;
  } generic_flit_t;
endpackage

module opn_local_ni
  import opn_local_ni_pkg::*;
#(
  parameter int TX_DEPTH    = 4,
  parameter int RX_DEPTH    = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tx_valid,
  input  generic_flit_t tx_flit,
  output logic          tx_ready,
  output logic          rx_valid,
  output generic_flit_t rx_flit,
  input  logic          rx_ready,
  output logic          net_req_out,
  output generic_flit_t net_flit_out,
  input  logic          net_ack_in,
  input  logic          net_req_in,
  input  generic_flit_t net_flit_in,
  output logic          net_ack_out,
  output logic          tx_idle,
  output logic          rx_overflow,
  output logic          timeout_err
);

  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int TX_CW = $clog2(TX_DEPTH + 1);
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int RX_CW = $clog2(RX_DEPTH + 1);

  // -------------------------------------------------------------------------
  // TX FIFO
  // -------------------------------------------------------------------------
  generic_flit_t      tx_mem_q [TX_DEPTH];
  logic [TX_AW-1:0]   tx_rd_q;
  logic [TX_AW-1:0]   tx_wr_q;
  logic [TX_CW-1:0]   tx_cnt_q;
  logic [TX_AW-1:0]   tx_rd_nxt;
  logic               tx_push;
  logic               tx_pop;
  generic_flit_t      tx_head;

  assign tx_ready  = (tx_cnt_q != TX_CW'(TX_DEPTH));
  assign tx_push   = tx_valid && tx_ready;
  assign tx_head   = tx_mem_q[tx_rd_q];
  assign tx_rd_nxt = tx_rd_q + TX_AW'(1);

  always_ff @(posedge clk) begin
    if (tx_push) begin
      tx_mem_q[tx_wr_q] <= tx_flit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_rd_q  <= '0;
      tx_wr_q  <= '0;
      tx_cnt_q <= '0;
    end else begin
      if (tx_push) tx_wr_q <= tx_wr_q + TX_AW'(1);
      if (tx_pop)  tx_rd_q <= tx_rd_nxt;
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt_q <= tx_cnt_q + TX_CW'(1);
        2'b01:   tx_cnt_q <= tx_cnt_q - TX_CW'(1);
        default: tx_cnt_q <= tx_cnt_q;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // TX FSM: IDLE -> SEND (one-cycle req) -> WAIT (ack or resend)
  // -------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } tx_state_t;

  tx_state_t     state_q, state_d;
  logic          req_q, req_d;
  generic_flit_t flit_q, flit_d;

  always_comb begin
    state_d = state_q;
    flit_d  = flit_q;
    tx_pop  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tx_cnt_q != '0) begin
          state_d = ST_SEND;
          flit_d  = tx_head;
        end
      end
      ST_SEND: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (net_ack_in) begin
          tx_pop = 1'b1;
          // The FIFO is still non-empty after the pop if another entry was
          // already queued or one is being pushed this very cycle. In the
          // latter case the new head is not in the array yet, so bypass it.
          if ((tx_cnt_q > TX_CW'(1)) || tx_push) begin
            state_d = ST_SEND;
            flit_d  = (tx_cnt_q == TX_CW'(1)) ? tx_flit : tx_mem_q[tx_rd_nxt];
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_SEND;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    req_d = (state_d == ST_SEND);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      flit_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      flit_q  <= flit_d;
    end
  end

  assign net_req_out  = req_q;
  assign net_flit_out = flit_q;
  assign tx_idle      = (tx_cnt_q == '0) && (state_q == ST_IDLE);

  // -------------------------------------------------------------------------
  // Optional ack timeout
  // -------------------------------------------------------------------------
`ifdef NI_ACK_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            timeout_q, timeout_d;

  always_comb begin
    to_cnt_d  = to_cnt_q;
    timeout_d = timeout_q;
    if ((state_q == ST_IDLE) && (state_d == ST_SEND)) begin
      to_cnt_d = '0;
    end else if (state_q == ST_WAIT) begin
      if (net_ack_in) begin
        to_cnt_d = '0;
      end else begin
        // Saturate so a permanently dead link cannot wrap the counter.
        if (to_cnt_q != TO_W'(TIMEOUT_CYC)) to_cnt_d = to_cnt_q + TO_W'(1);
        if (to_cnt_d == TO_W'(TIMEOUT_CYC)) timeout_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // RX FIFO: the router never stalls, so a full FIFO drops instead of waiting
  // -------------------------------------------------------------------------
  generic_flit_t    rx_mem_q [RX_DEPTH];
  logic [RX_AW-1:0] rx_rd_q;
  logic [RX_AW-1:0] rx_wr_q;
  logic [RX_CW-1:0] rx_cnt_q;
  logic             rx_full;
  logic             rx_push;
  logic             rx_pop;
  logic             ack_q;
  logic             ovf_q;

  // Full is judged on the registered count, ignoring a same-cycle pop.
  assign rx_full  = (rx_cnt_q == RX_CW'(RX_DEPTH));
  assign rx_push  = net_req_in && !rx_full;
  assign rx_valid = (rx_cnt_q != '0);
  assign rx_pop   = rx_valid && rx_ready;
  // Gate the head so rx_flit reads zero while the FIFO is empty.
  assign rx_flit  = rx_valid ? rx_mem_q[rx_rd_q] : '0;

  always_ff @(posedge clk) begin
    if (rx_push) begin
      rx_mem_q[rx_wr_q] <= net_flit_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_rd_q  <= '0;
      rx_wr_q  <= '0;
      rx_cnt_q <= '0;
      ack_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (rx_push) rx_wr_q <= rx_wr_q + RX_AW'(1);
      if (rx_pop)  rx_rd_q <= rx_rd_q + RX_AW'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt_q <= rx_cnt_q + RX_CW'(1);
        2'b01:   rx_cnt_q <= rx_cnt_q - RX_CW'(1);
        default: rx_cnt_q <= rx_cnt_q;
      endcase
      ack_q <= rx_push;
      if (net_req_in && rx_full) ovf_q <= 1'b1;
    end
  end

  assign net_ack_out = ack_q;
  assign rx_overflow = ovf_q;

endmodule

// File: tb/tb_opn_local_ni.sv
module tb_opn_local_ni;
  import opn_local_ni_pkg::*;

  localparam int TO_CYC = 4;

  logic          clk;
  logic          rst;
  logic          tx_valid;
  generic_flit_t tx_flit;
  logic          tx_ready;
  logic          rx_valid;
  generic_flit_t rx_flit;
  logic          rx_ready;
  logic          net_req_out;
  generic_flit_t net_flit_out;
  logic          net_ack_in;
  logic          net_req_in;
  generic_flit_t net_flit_in;
  logic          net_ack_out;
  logic          tx_idle;
  logic          rx_overflow;
  logic          timeout_err;

  opn_local_ni #(
    .TX_DEPTH   (4),
    .RX_DEPTH   (4),
    .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_valid    (tx_valid),
    .tx_flit     (tx_flit),
    .tx_ready    (tx_ready),
    .rx_valid    (rx_valid),
    .rx_flit     (rx_flit),
    .rx_ready    (rx_ready),
    .net_req_out (net_req_out),
    .net_flit_out(net_flit_out),
    .net_ack_in  (net_ack_in),
    .net_req_in  (net_req_in),
    .net_flit_in (net_flit_in),
    .net_ack_out (net_ack_out),
    .tx_idle     (tx_idle),
    .rx_overflow (rx_overflow),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  int checks = 0;
  int errors = 0;

`ifdef NI_ACK_TIMEOUT_EN
  localparam logic TO_EXP = 1'b1;
`else
  localparam logic TO_EXP = 1'b0;
`endif

  function automatic generic_flit_t mk(input int n);
    generic_flit_t f;
    f.ipriority = 2'(n);
    f.dst_x     = 4'(n >> 2);
    f.dst_y     = 4'(n >> 6);
    f.payload   = 32'hC0DE_0000 + 32'(n);
    return f;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic          tx_v;
    generic_flit_t tx_f;
    logic          ack_i;
    logic          req_i;
    generic_flit_t rf_i;
    logic          rx_rdy;
    logic          e_req;
    generic_flit_t e_nf;
    logic          e_txr;
    logic          e_idle;
    logic          e_ack;
    logic          e_rxv;
    generic_flit_t e_rf;
    logic          e_ovf;
  } vec_t;

  function automatic vec_t V(input logic tx_v, input int txn, input logic ack_i,
                             input logic req_i, input int rn, input logic rx_rdy,
                             input logic e_req, input int e_nf, input logic e_txr,
                             input logic e_idle, input logic e_ack, input logic e_rxv,
                             input int e_rf, input logic e_ovf);
    vec_t v;
    v.tx_v = tx_v;   v.tx_f = mk(txn);  v.ack_i = ack_i;
    v.req_i = req_i; v.rf_i = mk(rn);   v.rx_rdy = rx_rdy;
    v.e_req = e_req; v.e_nf = mk(e_nf); v.e_txr = e_txr;
    v.e_idle = e_idle; v.e_ack = e_ack; v.e_rxv = e_rxv;
    v.e_rf = mk(e_rf); v.e_ovf = e_ovf;
    return v;
  endfunction

  vec_t tbl [17];

  // ---------------- sequence driver state ----------------
  generic_flit_t tx_src[$], tx_sent[$], delivered[$], req_log[$];
  generic_flit_t rx_sent[$], rx_got[$];
  int            req_cyc[$];
  int            reject_left, rx_n, cyc, ack_bad, txr_low;
  logic          prev_req, prev_eject, eject_en, pop_en;
  generic_flit_t prev_flit;

  task automatic do_reset();
    rst = 1'b1; tx_valid = 1'b0; tx_flit = '0; net_ack_in = 1'b0;
    net_req_in = 1'b0; net_flit_in = '0; rx_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    tx_src.delete(); tx_sent.delete(); delivered.delete(); req_log.delete();
    rx_sent.delete(); rx_got.delete(); req_cyc.delete();
    reject_left = 0; cyc = -1; ack_bad = 0; txr_low = 0;
    prev_req = 1'b0; prev_eject = 1'b0; eject_en = 1'b0; pop_en = 1'b0;
    prev_flit = '0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " tx_ready"},    64'(tx_ready),     64'd1);
    chk({tag, " tx_idle"},     64'(tx_idle),      64'd1);
    chk({tag, " net_req_out"}, 64'(net_req_out),  64'd0);
    chk({tag, " net_flit"},    64'(net_flit_out), 64'd0);
    chk({tag, " rx_valid"},    64'(rx_valid),     64'd0);
    chk({tag, " rx_flit"},     64'(rx_flit),      64'd0);
    chk({tag, " net_ack_out"}, 64'(net_ack_out),  64'd0);
    chk({tag, " rx_overflow"}, 64'(rx_overflow),  64'd0);
    chk({tag, " timeout_err"}, 64'(timeout_err),  64'd0);
  endtask

  // Router + tile model, one iteration per cycle, evaluated at negedge.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      cyc++;
      net_ack_in = 1'b0;
      if (prev_req) begin
        if (reject_left > 0) begin
          reject_left--;
        end else begin
          net_ack_in = 1'b1;
          delivered.push_back(prev_flit);
        end
      end
      if (net_req_out) begin
        req_log.push_back(net_flit_out);
        req_cyc.push_back(cyc);
        $display("cycle %0d: req pulse flit %0h ack_next=%0d", cyc, net_flit_out, reject_left == 0);
      end
      prev_req  = net_req_out;
      prev_flit = net_flit_out;
      if (!tx_ready) txr_low++;
      if (tx_src.size() > 0) begin
        tx_valid = 1'b1;
        tx_flit  = tx_src[0];
        if (tx_ready) tx_sent.push_back(tx_src.pop_front());
      end else begin
        tx_valid = 1'b0;
      end
      if (net_ack_out !== prev_eject) ack_bad++;
      rx_ready = pop_en;
      if (rx_valid && pop_en) rx_got.push_back(rx_flit);
      net_req_in  = eject_en;
      net_flit_in = mk(rx_n);
      if (eject_en) begin
        rx_sent.push_back(mk(rx_n));
        rx_n++;
      end
      prev_eject = eject_en;
      @(negedge clk);
    end
  endtask

  initial begin
    // A = 1, router flits R0..R4 = 10..14
    tbl[0]  = V(1, 1, 0, 0, 0, 0,  0, 0, 1, 1, 0, 0, 0, 0);
    tbl[1]  = V(0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0, 0);
    tbl[2]  = V(0, 0, 0, 0, 0, 0,  1, 1, 1, 0, 0, 0, 0, 0);
    tbl[3]  = V(0, 0, 1, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0, 0);
    tbl[4]  = V(0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 0, 0, 0, 0);
    tbl[5]  = V(0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 0, 0, 0, 0);
    tbl[6]  = V(0, 0, 0, 1, 10, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    tbl[7]  = V(0, 0, 0, 1, 11, 0, 0, 0, 1, 1, 1, 1, 10, 0);
    tbl[8]  = V(0, 0, 0, 1, 12, 0, 0, 0, 1, 1, 1, 1, 10, 0);
    tbl[9]  = V(0, 0, 0, 1, 13, 0, 0, 0, 1, 1, 1, 1, 10, 0);
    tbl[10] = V(0, 0, 0, 1, 14, 0, 0, 0, 1, 1, 1, 1, 10, 0);
    tbl[11] = V(0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 0, 1, 10, 1);
    tbl[12] = V(0, 0, 0, 0, 0, 1,  0, 0, 1, 1, 0, 1, 10, 1);
    tbl[13] = V(0, 0, 0, 0, 0, 1,  0, 0, 1, 1, 0, 1, 11, 1);
    tbl[14] = V(0, 0, 0, 0, 0, 1,  0, 0, 1, 1, 0, 1, 12, 1);
    tbl[15] = V(0, 0, 0, 0, 0, 1,  0, 0, 1, 1, 0, 1, 13, 1);
    tbl[16] = V(0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 0, 0, 0, 1);

    // ---- reset state ----
    do_reset();
    check_reset("reset");

    // ---- single flit + RX overflow, cycle-by-cycle ----
    for (int r = 0; r < 17; r++) begin
      tx_valid    = tbl[r].tx_v;
      tx_flit     = tbl[r].tx_f;
      net_ack_in  = tbl[r].ack_i;
      net_req_in  = tbl[r].req_i;
      net_flit_in = tbl[r].rf_i;
      rx_ready    = tbl[r].rx_rdy;
      $display("row %0d: req_out=%0d tx_idle=%0d ack_out=%0d rx_valid=%0d rx_flit=%0h ovf=%0d",
               r, net_req_out, tx_idle, net_ack_out, rx_valid, rx_flit, rx_overflow);
      chk($sformatf("row%0d net_req_out", r), 64'(net_req_out), 64'(tbl[r].e_req));
      if (tbl[r].e_req) chk($sformatf("row%0d net_flit_out", r), 64'(net_flit_out), 64'(tbl[r].e_nf));
      chk($sformatf("row%0d tx_ready", r),    64'(tx_ready),    64'(tbl[r].e_txr));
      chk($sformatf("row%0d tx_idle", r),     64'(tx_idle),     64'(tbl[r].e_idle));
      chk($sformatf("row%0d net_ack_out", r), 64'(net_ack_out), 64'(tbl[r].e_ack));
      chk($sformatf("row%0d rx_valid", r),    64'(rx_valid),    64'(tbl[r].e_rxv));
      if (tbl[r].e_rxv) chk($sformatf("row%0d rx_flit", r), 64'(rx_flit), 64'(tbl[r].e_rf));
      chk($sformatf("row%0d rx_overflow", r), 64'(rx_overflow), 64'(tbl[r].e_ovf));
      @(negedge clk);
    end

    // ---- 4 flits, ack every attempt ----
    do_reset();
    for (int i = 0; i < 4; i++) tx_src.push_back(mk(20 + i));
    run(16);
    chk("burst pulse count", 64'(req_log.size()), 64'd4);
    for (int i = 0; i < 4 && i < req_log.size(); i++) begin
      chk($sformatf("burst order %0d", i), 64'(req_log[i]), 64'(mk(20 + i)));
      if (i > 0) chk($sformatf("burst spacing %0d", i), 64'(req_cyc[i] - req_cyc[i-1]), 64'd2);
    end
    chk("burst delivered", 64'(delivered.size()), 64'd4);
    chk("burst tx_ready never low", 64'(txr_low), 64'd0);
    chk("burst tx_idle", 64'(tx_idle), 64'd1);

    // ---- three rejections then ack ----
    do_reset();
    reject_left = 3;
    tx_src.push_back(mk(30));
    run(14);
    chk("retry pulse count", 64'(req_log.size()), 64'd4);
    for (int i = 0; i < req_log.size(); i++)
      chk($sformatf("retry flit %0d", i), 64'(req_log[i]), 64'(mk(30)));
    chk("retry delivered once", 64'(delivered.size()), 64'd1);
    chk("retry tx_idle", 64'(tx_idle), 64'd1);
    chk("retry no timeout", 64'(timeout_err), 64'd0);

    // ---- TX full with acks withheld, then drain ----
    do_reset();
    reject_left = 1000;
    for (int i = 0; i < 5; i++) tx_src.push_back(mk(60 + i));
    run(8);
    chk("full tx_ready", 64'(tx_ready), 64'd0);
    chk("full accepted", 64'(tx_sent.size()), 64'd4);
    reject_left = 0;
    run(30);
    chk("full delivered", 64'(delivered.size()), 64'd5);
    for (int i = 0; i < delivered.size() && i < 5; i++)
      chk($sformatf("full order %0d", i), 64'(delivered[i]), 64'(mk(60 + i)));
    chk("full tx_ready after drain", 64'(tx_ready), 64'd1);

    // ---- concurrent TX push, RX eject and RX pop ----
    do_reset();
    for (int i = 0; i < 20; i++) tx_src.push_back(mk(100 + i));
    eject_en = 1'b1;
    pop_en   = 1'b1;
    rx_n     = 200;
    run(20);
    eject_en = 1'b0;
    run(60);
    chk("mix tx delivered", 64'(delivered.size()), 64'd20);
    for (int i = 0; i < delivered.size() && i < 20; i++)
      chk($sformatf("mix tx order %0d", i), 64'(delivered[i]), 64'(mk(100 + i)));
    chk("mix rx received", 64'(rx_got.size()), 64'd20);
    for (int i = 0; i < rx_got.size() && i < 20; i++)
      chk($sformatf("mix rx order %0d", i), 64'(rx_got[i]), 64'(mk(200 + i)));
    chk("mix ack_out pattern", 64'(ack_bad), 64'd0);
    chk("mix no overflow", 64'(rx_overflow), 64'd0);

    // ---- ack never given ----
    do_reset();
    reject_left = 1000;
    tx_src.push_back(mk(50));
    run(9);
    chk("timeout after 3 retries", 64'(timeout_err), 64'd0);
    run(1);
    chk("timeout after 4 retries", 64'(timeout_err), 64'(TO_EXP));
    run(6);
    chk("timeout sticky", 64'(timeout_err), 64'(TO_EXP));
    chk("timeout still retrying", 64'(req_log.size() > 4), 64'd1);

    // ---- mid-operation reset drops the stuck flit ----
    do_reset();
    check_reset("midreset");
    run(6);
    chk("midreset no pulses", 64'(req_log.size()), 64'd0);
    chk("midreset tx_idle", 64'(tx_idle), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
